// File: rtl/spi_xmit_engine.sv
// SPI-slave transmit engine: byte/word loader and mode-0 MSB-first shifter.
// Host clock and chip select are synchronised into the system clock domain.
module spi_xmit_engine #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        extReset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        send,
  input  logic [31:0] sendData,
  input  logic [3:0]  disabledGroups,
  input  logic        writeMeta,
  input  logic [7:0]  meta_data,
  output logic        spi_miso,
  output logic        xmit_idle,
  output logic        byte_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;

  state_t      state_q, state_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [3:0]  pend_q, pend_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        xmit_idle_q, xmit_idle_d;
  logic        byte_done_q, byte_done_d;

  logic        sclk_s;
  logic        cs_s;
  logic        rise;
  logic        fall;
  logic [1:0]  first_sel;
  logic [7:0]  first_byte;
  logic [7:0]  cur_byte;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev_q;
  assign fall   = ~sclk_s & sclk_prev_q;

  // Next value of the synchroniser chains and the edge-detect sample.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sclk_prev_d = sclk_s;
  end

  // Synchroniser flops; preset to an idle bus (sclk low, cs deasserted).
  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  // Lowest pending byte lane is sent next, giving byte order 0..3.
  always_comb begin
    first_sel = 2'd3;
    if (pend_q[0])      first_sel = 2'd0;
    else if (pend_q[1]) first_sel = 2'd1;
    else if (pend_q[2]) first_sel = 2'd2;
    else                first_sel = 2'd3;
  end

  // Byte lanes of the word buffer for the next and the current byte.
  always_comb begin
    first_byte = wbuf_q[{first_sel, 3'b000} +: 8];
    cur_byte   = wbuf_q[{sel_q, 3'b000} +: 8];
  end

  // Transmit FSM next-state and datapath logic.
  always_comb begin
    state_d     = state_q;
    wbuf_d      = wbuf_q;
    pend_d      = pend_q;
    sel_d       = sel_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    byte_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (writeMeta) begin
          wbuf_d  = {24'h0, meta_data};
          pend_d  = 4'b0001;
          state_d = LOAD;
        end else if (send) begin
          wbuf_d  = sendData;
          pend_d  = ~disabledGroups;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (pend_q == 4'b0000) begin
          state_d = IDLE;
        end else begin
          sel_d    = first_sel;
          shreg_d  = first_byte;
          bitcnt_d = 4'd0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          // Host dropped the frame: restart this byte from its MSB.
          bitcnt_d = 4'd0;
          shreg_d  = cur_byte;
        end else if (rise) begin
          if (bitcnt_q == 4'd7) begin
            bitcnt_d      = 4'd8;
            pend_d[sel_q] = 1'b0;
            byte_done_d   = 1'b1;
            state_d       = LOAD;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else if (fall && bitcnt_q != 4'd0) begin
          shreg_d = {shreg_q[6:0], 1'b0};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    xmit_idle_d = (state_d == IDLE);
  end

  // FSM and datapath registers with registered status outputs.
  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      state_q     <= IDLE;
      wbuf_q      <= '0;
      pend_q      <= '0;
      sel_q       <= '0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      xmit_idle_q <= 1'b1;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wbuf_q      <= wbuf_d;
      pend_q      <= pend_d;
      sel_q       <= sel_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      xmit_idle_q <= xmit_idle_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign spi_miso  = ~cs_s & shreg_q[7];
  assign xmit_idle = xmit_idle_q;
  assign byte_done = byte_done_q;

endmodule

// File: tb/tb_spi_xmit_engine.sv
// Testbench for spi_xmit_engine: vector table, directed corners and
// randomized transfers checked against a byte-list reference model.
module tb_spi_xmit_engine;

  logic        clock = 1'b0;
  logic        extReset;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        send;
  logic [31:0] sendData;
  logic [3:0]  disabledGroups;
  logic        writeMeta;
  logic [7:0]  meta_data;
  logic        spi_miso;
  logic        xmit_idle;
  logic        byte_done;

  int n_chk  = 0;
  int n_pass = 0;
  int bd_cnt = 0;

  spi_xmit_engine #(.SYNC_STAGES(2)) dut (
    .clock          (clock),
    .extReset       (extReset),
    .spi_sclk       (spi_sclk),
    .spi_cs_n       (spi_cs_n),
    .send           (send),
    .sendData       (sendData),
    .disabledGroups (disabledGroups),
    .writeMeta      (writeMeta),
    .meta_data      (meta_data),
    .spi_miso       (spi_miso),
    .xmit_idle      (xmit_idle),
    .byte_done      (byte_done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (byte_done === 1'b1) bd_cnt++;

  typedef struct {
    string       nm;
    bit          meta;
    bit          snd;
    logic [7:0]  md;
    logic [31:0] sd;
    logic [3:0]  dis;
    int          glitch;
    bit          intrude;
    int          n_exp;
    logic [31:0] exp;
  } vec_t;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: the list of bytes a host should see, in order.
  function automatic void model(input bit m, input bit s,
                                input logic [7:0] md,
                                input logic [31:0] sd,
                                input logic [3:0] dis,
                                output int n, output logic [31:0] e);
    n = 0;
    e = '0;
    if (m) begin
      e[7:0] = md;
      n = 1;
    end else if (s) begin
      for (int k = 0; k < 4; k++) begin
        if (!dis[k]) begin
          e[8*n +: 8] = sd[8*k +: 8];
          n++;
        end
      end
    end
  endfunction

  // Strobe in one cycle, then clock out n_exp bytes as an SPI mode-0 host.
  task automatic run_xfer(input vec_t v);
    logic [7:0] b;
    logic [7:0] b0;
    int bd0;
    b0  = v.exp[7:0];
    bd0 = bd_cnt;
    meta_data      = v.md;
    sendData       = v.sd;
    disabledGroups = v.dis;
    writeMeta      = v.meta;
    send           = v.snd;
    step(1);
    writeMeta = 1'b0;
    send      = 1'b0;
    chk({v.nm, ".idle_n1"}, {31'd0, xmit_idle}, 32'd0);
    step(1);
    if (v.n_exp > 0)
      chk({v.nm, ".msb_n2"}, {31'd0, spi_miso}, {31'd0, b0[7]});
    for (int i = 0; i < v.n_exp; i++) begin
      if (i == 0 && v.glitch > 0) begin
        for (int j = 0; j < v.glitch; j++) begin
          spi_sclk = 1'b1;
          step(5);
          spi_sclk = 1'b0;
          step(5);
        end
        spi_cs_n = 1'b1;
        step(8);
        chk({v.nm, ".miso_cs_hi"}, {31'd0, spi_miso}, 32'd0);
        spi_cs_n = 1'b0;
        step(6);
        chk({v.nm, ".msb_restart"}, {31'd0, spi_miso}, {31'd0, b0[7]});
      end
      b = '0;
      for (int j = 0; j < 8; j++) begin
        spi_sclk = 1'b1;
        b = {b[6:0], spi_miso};
        if (v.intrude && i == 0 && j == 3) begin
          step(1);
          writeMeta = 1'b1;
          send      = 1'b1;
          meta_data = 8'h99;
          step(1);
          writeMeta = 1'b0;
          send      = 1'b0;
          step(3);
        end else begin
          step(5);
        end
        spi_sclk = 1'b0;
        step(5);
      end
      chk($sformatf("%s.byte%0d", v.nm, i), {24'd0, b},
          {24'd0, v.exp[8*i +: 8]});
    end
    step(3);
    chk({v.nm, ".idle_end"}, {31'd0, xmit_idle}, 32'd1);
    chk({v.nm, ".bd_count"}, bd_cnt - bd0, v.n_exp);
  endtask

  vec_t vt[$];
  vec_t v;

  initial begin
    extReset       = 1'b1;
    spi_sclk       = 1'b0;
    spi_cs_n       = 1'b1;
    send           = 1'b0;
    sendData       = '0;
    disabledGroups = '0;
    writeMeta      = 1'b0;
    meta_data      = '0;
    #1;
    chk("rst.idle", {31'd0, xmit_idle}, 32'd1);
    chk("rst.bd", {31'd0, byte_done}, 32'd0);
    chk("rst.miso", {31'd0, spi_miso}, 32'd0);
    step(3);
    extReset = 1'b0;
    step(2);
    chk("rst.idle_after", {31'd0, xmit_idle}, 32'd1);
    spi_cs_n = 1'b0;
    step(4);

    vt.push_back('{"meta_a5", 1, 0, 8'hA5, 32'h0, 4'h0, 0, 0,
                   1, 32'h000000A5});
    vt.push_back('{"send_mask5", 0, 1, 8'h00, 32'h44332211, 4'b0101, 0, 0,
                   2, 32'h00004422});
    vt.push_back('{"send_allmask", 0, 1, 8'h00, 32'h12345678, 4'hF, 0, 0,
                   0, 32'h0});
    vt.push_back('{"meta_c3_cs", 1, 0, 8'hC3, 32'h0, 4'h0, 3, 0,
                   1, 32'h000000C3});
    vt.push_back('{"meta_11_intr", 1, 0, 8'h11, 32'h0, 4'h0, 0, 1,
                   1, 32'h00000011});
    vt.push_back('{"both_meta_wins", 1, 1, 8'h5A, 32'hFFFFFFFF, 4'h0, 0, 0,
                   1, 32'h0000005A});
    vt.push_back('{"send_all4", 0, 1, 8'h00, 32'hDEADBEEF, 4'h0, 0, 0,
                   4, 32'hDEADBEEF});
    vt.push_back('{"send_b3only", 0, 1, 8'h00, 32'h81000000, 4'b0111, 0, 0,
                   1, 32'h00000081});
    foreach (vt[i]) run_xfer(vt[i]);

    // Asynchronous reset in the middle of a byte.
    writeMeta = 1'b1;
    meta_data = 8'hFF;
    step(1);
    writeMeta = 1'b0;
    step(1);
    for (int j = 0; j < 3; j++) begin
      spi_sclk = 1'b1;
      step(5);
      spi_sclk = 1'b0;
      step(5);
    end
    spi_sclk = 1'b1;
    step(2);
    chk("rstmid.miso_before", {31'd0, spi_miso}, 32'd1);
    chk("rstmid.idle_before", {31'd0, xmit_idle}, 32'd0);
    #2;
    extReset = 1'b1;
    #1;
    chk("rstmid.miso", {31'd0, spi_miso}, 32'd0);
    chk("rstmid.idle", {31'd0, xmit_idle}, 32'd1);
    spi_sclk = 1'b0;
    step(2);
    extReset = 1'b0;
    step(4);
    run_xfer('{"after_rst_5a", 1, 0, 8'h5A, 32'h0, 4'h0, 0, 0,
               1, 32'h0000005A});

    // Randomized transfers against the byte-list model.
    for (int t = 0; t < 24; t++) begin
      int r;
      r = $urandom_range(0, 3);
      v.nm   = $sformatf("rand%0d", t);
      v.meta = r[0];
      v.snd  = r[1] | ~r[0];
      v.md   = 8'($urandom);
      v.sd   = $urandom;
      v.dis  = 4'($urandom_range(0, 15));
      v.glitch  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      v.intrude = ($urandom_range(0, 4) == 0);
      model(v.meta, v.snd, v.md, v.sd, v.dis, v.n_exp, v.exp);
      run_xfer(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
